rename_stage: RTL
=================

Name: rename_stage

Overview:
- Register-rename stage directly downstream of instruction decode in the out-of-order RISC-V core.
- Consumes decoded architectural register fields (srcReg1, srcReg2, destReg, regWrite).
- Maps each field to a physical register tag through a register alias table (RAT) and allocates destination tags from a FIFO free list.
- Presents renamed results through a one-deep output register with valid/ready handshake toward dispatch; retiring instructions return old tags to the free list.

Parameters:
- ARCH_REGS, 32: architectural registers.
- PHYS_REGS, 64: physical registers.
- PREG_W, 6: physical tag width, equal to log2(PHYS_REGS).
- FL_DEPTH, 32: free-list depth, equal to PHYS_REGS - ARCH_REGS.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage accepts the instruction this cycle.
- srcReg1  input  5  architectural source 1.
- srcReg2  input  5  architectural source 2.
- destReg  input  5  architectural destination.
- regWrite  input  1  instruction writes destReg.
- out_valid  output  1  renamed instruction valid.
- out_ready  input  1  dispatch accepts the renamed instruction.
- out_psrc1  output  PREG_W  physical tag for source 1.
- out_psrc2  output  PREG_W  physical tag for source 2.
- out_pdest  output  PREG_W  newly allocated destination tag.
- out_old_pdest  output  PREG_W  previous mapping of destReg, freed at retire.
- out_archDest  output  5  architectural destination, passed through.
- out_regWrite  output  1  regWrite, passed through.
- retire_valid  input  1  retiring instruction frees a tag.
- retire_pdest  input  PREG_W  tag to return to the free list.
- free_count  output  6  entries currently in the free list, range 0..32.

Behaviour:
- Reset (async, rstn low): RAT[i]=i for i=0..31.
  - Free list holds tags 32..63 in ascending order; head=0, tail=0, free_count=32.
  - out_valid=0; all out_* data outputs = 0.
  - An in-flight instruction is dropped.
- Allocation condition: alloc = regWrite && destReg!=0.
- in_ready = (!out_valid || out_ready) && (!alloc || free_count!=0).
  - Combinational from current inputs and registered state only.
  - A tag retired in the same cycle does not bypass into in_ready.
- Accept: in_valid && in_ready. Latency is one cycle; on the accept edge:
  - out_psrc1 <= RAT[srcReg1]; out_psrc2 <= RAT[srcReg2]. Sources read the pre-update RAT, so an instruction whose source equals its own destination sees the old tag.
  - If alloc: out_pdest <= freelist[head]; out_old_pdest <= RAT[destReg]; RAT[destReg] <= freelist[head]; head increments mod 32.
  - If !alloc: out_pdest <= 0; out_old_pdest <= 0; RAT unchanged.
  - out_archDest and out_regWrite are registered from the inputs.
  - out_valid <= 1.
- Architectural x0 always maps to tag 0; RAT[0] is never written.
- No accept and out_ready=1: out_valid <= 0; data outputs hold their last values.
- No accept and out_ready=0: all outputs hold. RAT and free list are unchanged by the stalled instruction.
- Retire: if retire_valid && retire_pdest!=0, then freelist[tail] <= retire_pdest and tail increments mod 32. retire_pdest=0 is ignored.
- free_count next value = free_count - (accept && alloc) + (retire push). Simultaneous allocate and retire leaves free_count unchanged.
- Overflow (retire push at free_count=32) is illegal upstream. The push is dropped and free_count saturates at 32.
- Underflow cannot occur because in_ready gates allocation.

Test Plan:
1. Reset, then accept srcReg1=1, srcReg2=2, destReg=5, regWrite=1 -> next cycle out_psrc1=1, out_psrc2=2, out_pdest=32, out_old_pdest=5, free_count=31. Follow with srcReg1=5, srcReg2=5, destReg=6 -> out_psrc1=32, out_psrc2=32, out_pdest=33, out_old_pdest=6.
2. destReg=0 with regWrite=1, then destReg=7 with regWrite=0 -> out_pdest=0, out_old_pdest=0, free_count stays 32, RAT[7]=7.
3. 32 back-to-back allocations with no retire -> free_count=0. A writing instruction then sees in_ready=0, while a regWrite=0 instruction is still accepted. Retire retire_pdest=5 -> free_count=1 next cycle, and the next allocation gets pdest=5 (wrap-around).
4. out_valid=1 with out_ready=0 held 3 cycles while in_valid=1 -> outputs stable, in_ready=0, RAT and free_count unchanged. Raise out_ready -> pending instruction accepted in the same cycle.
5. free_count=1: allocate and retire pdest=40 in the same cycle -> free_count stays 1, and the next allocation returns 40.
6. Pull rstn low mid-stream, asynchronous to clk -> out_valid=0 immediately, free_count=32, and the next rename of destReg=3 gets pdest=32, out_old_pdest=3.

Source files
------------

// File: rtl/rename_stage.sv
// Register-rename stage: maps architectural source/destination registers to
// physical tags through a register alias table (RAT), allocates destination
// tags from a circular free list, and presents the renamed instruction through
// a one-deep valid/ready output register. Retired tags return to the free list.
module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PREG_W    = $clog2(PHYS_REGS),
  parameter int FL_DEPTH  = PHYS_REGS - ARCH_REGS
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        srcReg1,
  input  logic [4:0]        srcReg2,
  input  logic [4:0]        destReg,
  input  logic              regWrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_psrc1,
  output logic [PREG_W-1:0] out_psrc2,
  output logic [PREG_W-1:0] out_pdest,
  output logic [PREG_W-1:0] out_old_pdest,
  output logic [4:0]        out_archDest,
  output logic              out_regWrite,
  input  logic              retire_valid,
  input  logic [PREG_W-1:0] retire_pdest,
  output logic [5:0]        free_count
);

  localparam int FW = $clog2(FL_DEPTH);

  // Register alias table and free list storage
  logic [PREG_W-1:0] rat_q [ARCH_REGS];
  logic [PREG_W-1:0] rat_d [ARCH_REGS];
  logic [PREG_W-1:0] fl_q  [FL_DEPTH];
  logic [PREG_W-1:0] fl_d  [FL_DEPTH];
  logic [FW-1:0]     head_q, head_d;
  logic [FW-1:0]     tail_q, tail_d;
  logic [5:0]        fc_q, fc_d;

  // Output register
  logic              out_valid_q, out_valid_d;
  logic [PREG_W-1:0] out_psrc1_q, out_psrc1_d;
  logic [PREG_W-1:0] out_psrc2_q, out_psrc2_d;
  logic [PREG_W-1:0] out_pdest_q, out_pdest_d;
  logic [PREG_W-1:0] out_old_pdest_q, out_old_pdest_d;
  logic [4:0]        out_arch_dest_q, out_arch_dest_d;
  logic              out_reg_write_q, out_reg_write_d;

  logic alloc;
  logic accept;
  logic alloc_fire;
  logic push;

  // Handshake, rename lookup, allocation and retire next-state logic
  always_comb begin
    rat_d           = rat_q;
    fl_d            = fl_q;
    head_d          = head_q;
    tail_d          = tail_q;
    out_valid_d     = out_valid_q;
    out_psrc1_d     = out_psrc1_q;
    out_psrc2_d     = out_psrc2_q;
    out_pdest_d     = out_pdest_q;
    out_old_pdest_d = out_old_pdest_q;
    out_arch_dest_d = out_arch_dest_q;
    out_reg_write_d = out_reg_write_q;

    // x0 never allocates, so it stays pinned to tag 0
    alloc      = regWrite && (destReg != 5'd0);
    // Readiness uses registered free_count only; a same-cycle retire does not help
    in_ready   = (!out_valid_q || out_ready) && (!alloc || (fc_q != 6'd0));
    accept     = in_valid && in_ready;
    alloc_fire = accept && alloc;
    // A push into a full list is dropped unless a pop frees a slot the same cycle
    push       = retire_valid && (retire_pdest != '0) &&
                 ((fc_q != 6'(FL_DEPTH)) || alloc_fire);

    if (accept) begin
      // Sources read the pre-update RAT so src==dest sees the old mapping
      out_psrc1_d     = rat_q[srcReg1];
      out_psrc2_d     = rat_q[srcReg2];
      out_arch_dest_d = destReg;
      out_reg_write_d = regWrite;
      out_valid_d     = 1'b1;
      if (alloc) begin
        out_pdest_d     = fl_q[head_q];
        out_old_pdest_d = rat_q[destReg];
        rat_d[destReg]  = fl_q[head_q];
        head_d          = head_q + FW'(1);
      end else begin
        out_pdest_d     = '0;
        out_old_pdest_d = '0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (push) begin
      fl_d[tail_q] = retire_pdest;
      tail_d       = tail_q + FW'(1);
    end

    fc_d = fc_q - {5'd0, alloc_fire} + {5'd0, push};
  end

  // State registers with asynchronous reset to the identity mapping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= PREG_W'(i);
      for (int i = 0; i < FL_DEPTH; i++)  fl_q[i]  <= PREG_W'(ARCH_REGS + i);
      head_q          <= '0;
      tail_q          <= '0;
      fc_q            <= 6'(FL_DEPTH);
      out_valid_q     <= 1'b0;
      out_psrc1_q     <= '0;
      out_psrc2_q     <= '0;
      out_pdest_q     <= '0;
      out_old_pdest_q <= '0;
      out_arch_dest_q <= '0;
      out_reg_write_q <= 1'b0;
    end else begin
      rat_q           <= rat_d;
      fl_q            <= fl_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      fc_q            <= fc_d;
      out_valid_q     <= out_valid_d;
      out_psrc1_q     <= out_psrc1_d;
      out_psrc2_q     <= out_psrc2_d;
      out_pdest_q     <= out_pdest_d;
      out_old_pdest_q <= out_old_pdest_d;
      out_arch_dest_q <= out_arch_dest_d;
      out_reg_write_q <= out_reg_write_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_psrc1     = out_psrc1_q;
  assign out_psrc2     = out_psrc2_q;
  assign out_pdest     = out_pdest_q;
  assign out_old_pdest = out_old_pdest_q;
  assign out_archDest  = out_arch_dest_q;
  assign out_regWrite  = out_reg_write_q;
  assign free_count    = fc_q;

endmodule
